// File: rtl/uc_io_hs.sv
`default_nettype none
// ============================================================================
// Module   : uc_io_hs
// Brief    : Maquina Sencilla control unit whose IN/OUT states use valid/ready
//            handshakes. Define UC_IO_TIMEOUT_EN for the I/O timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module uc_io_hs #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c3,
  input  logic        c2,
  input  logic        c1,
  input  logic        c0,
  input  logic        fz,
  input  logic        in_valid,
  input  logic        out_ready,
  output logic [11:0] out,
  output logic        in_ack,
  output logic        out_valid,
  output logic        fault,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_OPA    = 4'd2,
    S_OPB    = 4'd6,
    S_WR     = 4'd7,
    S_CMP    = 4'd9,
    S_MOV    = 4'd10,
    S_BR     = 4'd11,
    S_FAULT  = 4'd13,
    S_IN     = 4'd14,
    S_OUT    = 4'd15
  } state_t;

  localparam logic [11:0] C_CW_FETCH = 12'b000001100000;
  localparam logic [11:0] C_CW_OPA   = 12'b100000001000;
  localparam logic [11:0] C_CW_OPB   = 12'b110000010000;
  localparam logic [11:0] C_CW_WR    = 12'b110010000100;
  localparam logic [11:0] C_CW_CMP   = 12'b000100000100;
  localparam logic [11:0] C_CW_MOV   = 12'b111010000100;
  localparam logic [11:0] C_CW_BR    = 12'b110001100000;
  localparam logic [11:0] C_CW_IN    = 12'b111010000010;
  localparam logic [11:0] C_CW_OUT   = 12'b111000000101;

  state_t r_state;
  state_t w_next;
  logic   w_hs;
  logic   w_wait;
  logic   w_expire;

  assign w_hs   = ((r_state == S_IN) && in_valid) || ((r_state == S_OUT) && out_ready);
  assign w_wait = ((r_state == S_IN) || (r_state == S_OUT)) && !w_hs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if ({c1, c0} != 2'b11) w_next = S_OPA;
        else if (!c3)          w_next = fz ? S_BR : S_FETCH;
        else if (!c2)          w_next = S_IN;
        else                   w_next = S_OUT;
      end
      // Opcode bits can change after DECODE; an 11 here falls back to FETCH.
      S_OPA: begin
        if (!c1)      w_next = S_OPB;
        else if (!c0) w_next = S_MOV;
        else          w_next = S_FETCH;
      end
      S_OPB:        w_next = c0 ? S_CMP : S_WR;
      S_BR:         w_next = S_DECODE;
      S_FAULT:      w_next = S_FAULT;
      S_IN, S_OUT: begin
        if (w_expire)    w_next = S_FAULT;
        else if (w_wait) w_next = r_state;
        else             w_next = S_FETCH;
      end
      default:      w_next = S_FETCH;
    endcase
  end

  always_comb begin
    out = 12'd0;
    case (r_state)
      S_FETCH: out = C_CW_FETCH;
      S_OPA:   out = C_CW_OPA;
      S_OPB:   out = C_CW_OPB;
      S_WR:    out = C_CW_WR;
      S_CMP:   out = C_CW_CMP;
      S_MOV:   out = C_CW_MOV;
      S_BR:    out = C_CW_BR;
      S_IN:    out = in_valid  ? C_CW_IN  : 12'd0;
      S_OUT:   out = out_ready ? C_CW_OUT : 12'd0;
      default: out = 12'd0;
    endcase
  end

  assign in_ack    = (r_state == S_IN) && in_valid;
  assign out_valid = (r_state == S_OUT);
  assign state     = r_state;

`ifdef UC_IO_TIMEOUT_EN
  logic [TO_W-1:0] r_cnt;
  logic            r_fault;
  logic            w_enter_io;

  assign w_enter_io = ((w_next == S_IN) || (w_next == S_OUT)) && (w_next != r_state);
  assign w_expire   = w_wait && (r_cnt == TO_W'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      if (w_enter_io)                  r_cnt <= '0;
      else if (w_wait && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
      if (w_expire)                    r_fault <= 1'b1;
    end
  end

  assign fault = r_fault;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TO_W, TIMEOUT};
  assign w_expire   = 1'b0;
  assign fault      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/uc_io_hs.md
# uc_io_hs

Handshaked, parametrised control unit for the Maquina Sencilla datapath with I/O. It decodes the opcode bits and the zero flag into the 12-bit control word `out`, as the base control unit does. IN and OUT execute through valid/ready handshakes with external I/O, so a slow peripheral stalls the sequencer. An optional timeout watchdog moves the unit into a sticky fault state when a peripheral never responds.

## Interface
- `TO_W`, default 8: width of the wait/timeout counter.
- `TIMEOUT`, default 200: wait cycles tolerated in states 14/15 before fault. Legal range 1..2^TO_W-1. Used only with `UC_IO_TIMEOUT_EN`.
- `clk` input, 1: clock; all state updates on the rising edge.
- `reset` input, 1: asynchronous, active-low reset.
- `c3`, `c2`, `c1`, `c0` input, 1 each: opcode bits from the instruction register.
- `fz` input, 1: zero flag from the datapath.
- `in_valid` input, 1: the peripheral presents input data.
- `out_ready` input, 1: the peripheral accepts output data.
- `out` output, 12: datapath control word.
- `in_ack` output, 1: input data consumed this cycle.
- `out_valid` output, 1: output data on the bus is valid.
- `fault` output, 1: sticky I/O timeout flag.
- `state` output, 4: current state code, for debug.

## Operation
- Control words are Moore outputs decoded from `state`. No don't-cares: unused bits are driven 0.
  - 0 FETCH: 000001100000
  - 1 DECODE: 000000000000
  - 2 OPA: 100000001000
  - 6 OPB: 110000010000
  - 7 WR: 110010000100
  - 9 CMP: 000100000100
  - 10 MOV: 111010000100
  - 11 BR: 110001100000
  - 13 FAULT: 000000000000
  - 14 IN: 111010000010 when `in_valid`=1, else 0
  - 15 OUT: 111000000101 when `out_ready`=1, else 0
- Transitions:
  - 0 → 1.
  - 1: if {c1,c0}≠11 → 2. If 11 and c3=0: fz=1 → 11, fz=0 → 0. If 11 and {c3,c2}=10 → 14. If 11 and {c3,c2}=11 → 15.
  - 2: c1=0 → 6. {c1,c0}=10 → 10.
  - 6: c0=0 → 7. c0=1 → 9.
  - 7, 9 and 10 → 0.
  - 11 → 1.
  - 14: `in_valid`=1 → 0, otherwise hold.
  - 15: `out_ready`=1 → 0, otherwise hold.
  - 13: hold until reset.
  - Any unlisted state/opcode combination → 0. This is a change from "hold"; the unit must never lock up on an illegal code.
- Handshake outputs:
  - `in_ack` = (state==14) & `in_valid`.
  - `out_valid` = (state==15).
  - The I/O control words are gated by the handshake input. Register writes therefore happen exactly once, in the acceptance cycle.
- Wait counter:
  - Cleared to 0 on every transition into state 14 or 15.
  - Increments by 1 for each cycle spent waiting; saturates at 2^TO_W-1.
- `state` mirrors the internal register.

## Timing
- Reset (`reset`=0), asynchronous: state=0, counter=0, `fault`=0. Outputs immediately become `out`=000001100000, `in_ack`=0, `out_valid`=0.
- Release is synchronous to the next rising edge. The first edge with `reset`=1 moves 0 → 1.
- Latency (FETCH to the next FETCH):
  - ALU/MOV instruction: 5 cycles (0,1,2,6,7/9).
  - MOV via state 10: 4 cycles.
  - Branch not taken: 2 cycles.
  - Branch taken: 3 cycles to DECODE.
  - IN/OUT: 3 cycles if the handshake input is already 1 on entry, otherwise 3 + N wait cycles.
- `in_valid` and `out_ready` are sampled combinationally. A handshake input rising in the same cycle the unit enters 14/15 completes that cycle.
- Reset asserted mid-handshake aborts immediately. `out_valid` and `in_ack` drop asynchronously.

## Configuration
- `UC_IO_TIMEOUT_EN` defined:
  - In state 14/15, when the counter equals `TIMEOUT` and the handshake input is still 0, the next edge goes to 13 and sets `fault`=1.
  - `fault` stays 1 until reset.
  - If the handshake arrives in the same cycle the counter reaches `TIMEOUT`, the handshake wins: no fault, → 0.
- `UC_IO_TIMEOUT_EN` undefined:
  - States 14/15 wait indefinitely.
  - `fault` is tied to 0 and state 13 is unreachable.
  - The counter logic is removed; `TO_W` and `TIMEOUT` are ignored.

## Test plan
- Reset low mid-instruction (state 6) → `state`=0 and `out`=000001100000 without a clock edge. After release: 0→1→2 on consecutive edges.
- ADD, {c3..c0}=0001 → state sequence 0,1,2,6,9,0. `out` in the state-9 cycle = 000100000100.
- BEQ, {c3..c0}=0011 with fz=1 → 0,1,11,1. With fz=0 → 0,1,0.
- IN, {c3..c0}=1011, `in_valid` low for 5 cycles then high:
  - 5 cycles in state 14 with `out`=0 and `in_ack`=0.
  - Then one cycle with `out`=111010000010 and `in_ack`=1, then state 0.
- OUT, {c3..c0}=1111, `out_ready` already 1 on entry:
  - `out_valid`=1 and `out`=111000000101 for exactly one cycle, then state 0.
- With `UC_IO_TIMEOUT_EN`, `TIMEOUT`=4, `out_ready` held 0:
  - Enter 15, then after 5 wait cycles → state 13, `fault`=1.
  - `fault` persists until `reset`=0.
  - Repeat with `out_ready`=1 in the 5th wait cycle → no fault.
